fr_normalizer: RTL and testbench

//  Post-adder stage of the floating MAC. Takes the 24-bit fraction sum, carry-out (overflow_signal)
//  and sign from the pipelined fraction adder, plus the common biased exponent of the aligned operands.

---
 rtl/fr_normalizer_if.sv | 34 +++
 rtl/fr_normalizer.sv | 170 +++++++++++++++++
 tb/tb_fr_normalizer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fr_normalizer_if.sv
// Handshake and data bundle between the fraction adder, the normaliser and its consumer.
// The master drives operands and out_ready; the slave (the normaliser) drives results.
interface fr_normalizer_if #(
  parameter int FRAC_W = 24,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [FRAC_W-1:0] frac_in;
  logic              overflow_in;
  logic              sign_in;
  logic [EXP_W-1:0]  exp_in;

  logic              out_valid;
  logic              out_ready;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [FRAC_W-2:0] frac_out;
  logic              zero_flag;
  logic              exp_overflow;
  logic              exp_underflow;

  modport master (
    output in_valid, frac_in, overflow_in, sign_in, exp_in, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, frac_out,
           zero_flag, exp_overflow, exp_underflow
  );

  modport slave (
    input  in_valid, frac_in, overflow_in, sign_in, exp_in, out_ready,
    output in_ready, out_valid, sign_out, exp_out, frac_out,
           zero_flag, exp_overflow, exp_underflow
  );
endinterface

// File: rtl/fr_normalizer.sv
// Post-adder normaliser of the floating MAC: shifts the adder sum left one bit per cycle
// until the hidden bit is set, then rounds to nearest-even and packs sign/exponent/fraction.
module fr_normalizer #(
  parameter int FRAC_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic            clock,
  input  logic            reset,
  fr_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  // Two guard bits keep exp_in+1 and the round-up carry representable without wrap.
  localparam logic signed [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [FRAC_W-1:0]       MANT_HIDDEN = {1'b1, {(FRAC_W-1){1'b0}}};

  state_t                  state, state_n;
  logic [FRAC_W-1:0]       mant, mant_n;
  logic                    guard, guard_n;
  logic signed [EXP_W+1:0] exp_r, exp_n;
  logic                    sign_r, sign_n;

  logic                    sign_out_r, sign_out_n;
  logic [EXP_W-1:0]        exp_out_r, exp_out_n;
  logic [FRAC_W-2:0]       frac_out_r, frac_out_n;
  logic                    zero_r, zero_n;
  logic                    ovf_r, ovf_n;
  logic                    unf_r, unf_n;

  logic [FRAC_W:0]         rounded;
  logic [FRAC_W-1:0]       r_mant;
  logic signed [EXP_W+1:0] r_exp;
  logic                    accept;

  assign bus.in_ready      = (state == IDLE) && !reset;
  assign bus.out_valid     = (state == DONE);
  assign bus.sign_out      = sign_out_r;
  assign bus.exp_out       = exp_out_r;
  assign bus.frac_out      = frac_out_r;
  assign bus.zero_flag     = zero_r;
  assign bus.exp_overflow  = ovf_r;
  assign bus.exp_underflow = unf_r;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      mant       <= '0;
      guard      <= 1'b0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      sign_out_r <= 1'b0;
      exp_out_r  <= '0;
      frac_out_r <= '0;
      zero_r     <= 1'b0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
    end else begin
      state      <= state_n;
      mant       <= mant_n;
      guard      <= guard_n;
      exp_r      <= exp_n;
      sign_r     <= sign_n;
      sign_out_r <= sign_out_n;
      exp_out_r  <= exp_out_n;
      frac_out_r <= frac_out_n;
      zero_r     <= zero_n;
      ovf_r      <= ovf_n;
      unf_r      <= unf_n;
    end
  end

  always_comb begin
    state_n    = state;
    mant_n     = mant;
    guard_n    = guard;
    exp_n      = exp_r;
    sign_n     = sign_r;
    sign_out_n = sign_out_r;
    exp_out_n  = exp_out_r;
    frac_out_n = frac_out_r;
    zero_n     = zero_r;
    ovf_n      = ovf_r;
    unf_n      = unf_r;

    // Round-to-nearest-even with no sticky bit: only an exact tie on an odd LSB rounds up.
    rounded = {1'b0, mant} + {{FRAC_W{1'b0}}, guard & mant[0]};
    if (rounded[FRAC_W]) begin
      r_mant = MANT_HIDDEN;
      r_exp  = exp_r + EXP_ONE;
    end else begin
      r_mant = rounded[FRAC_W-1:0];
      r_exp  = exp_r;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          sign_n = bus.sign_in;
          if (bus.overflow_in) begin
            mant_n  = {1'b1, bus.frac_in[FRAC_W-1:1]};
            guard_n = bus.frac_in[0];
            exp_n   = {2'b00, bus.exp_in} + EXP_ONE;
            state_n = ROUND;
          end else if (bus.frac_in == '0) begin
            sign_out_n = 1'b0;
            exp_out_n  = '0;
            frac_out_n = '0;
            zero_n     = 1'b1;
            ovf_n      = 1'b0;
            unf_n      = 1'b0;
            state_n    = DONE;
          end else begin
            mant_n  = bus.frac_in;
            guard_n = 1'b0;
            exp_n   = {2'b00, bus.exp_in};
            state_n = NORM;
          end
        end
      end

      NORM: begin
        if (mant[FRAC_W-1]) begin
          state_n = ROUND;
        end else if (exp_r <= EXP_ONE) begin
          sign_out_n = sign_r;
          exp_out_n  = '0;
          frac_out_n = '0;
          zero_n     = 1'b1;
          ovf_n      = 1'b0;
          unf_n      = 1'b1;
          state_n    = DONE;
        end else begin
          mant_n = {mant[FRAC_W-2:0], 1'b0};
          exp_n  = exp_r - EXP_ONE;
        end
      end

      ROUND: begin
        mant_n     = r_mant;
        exp_n      = r_exp;
        sign_out_n = sign_r;
        zero_n     = 1'b0;
        unf_n      = 1'b0;
        if (r_exp >= EXP_MAX) begin
          exp_out_n  = {EXP_W{1'b1}};
          frac_out_n = '0;
          ovf_n      = 1'b1;
        end else begin
          exp_out_n  = r_exp[EXP_W-1:0];
          frac_out_n = r_mant[FRAC_W-2:0];
          ovf_n      = 1'b0;
        end
        state_n = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fr_normalizer.sv
// Bench for fr_normalizer: directed corner cases plus random operands, each result
// compared with an arithmetic reference model including latency and backpressure hold.
module tb_fr_normalizer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fr_normalizer_if bus ();

  fr_normalizer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sign;
    logic [7:0]  e;
    logic [22:0] f;
    logic        zero;
    logic        ovf;
    logic        unf;
    int          lat;
  } result_t;

  // Value-level model: count leading zeros, shift once, round the 25-bit carry case.
  function automatic result_t model(input logic [23:0] frac, input logic ovf,
                                    input logic sgn, input logic [7:0] e_in);
    result_t r;
    longint  v, m;
    int      k, e;
    r.sign = 1'b0; r.e = '0; r.f = '0;
    r.zero = 1'b0; r.ovf = 1'b0; r.unf = 1'b0; r.lat = 0;
    if (!ovf && frac == 24'd0) begin
      r.zero = 1'b1;
      r.lat  = 1;
      return r;
    end
    r.sign = sgn;
    if (ovf) begin
      v = (longint'(1) << 24) | longint'(frac);
      m = v >> 1;
      e = int'(e_in) + 1;
      if ((v & 1) != 0 && (m & 1) != 0) m = m + 1;
      if (m == (longint'(1) << 24)) begin
        m = longint'(1) << 23;
        e = e + 1;
      end
      r.lat = 2;
    end else begin
      k = 0;
      while (frac[23-k] == 1'b0) k++;
      if (k > 0 && int'(e_in) < k + 1) begin
        r.zero = 1'b1;
        r.unf  = 1'b1;
        r.lat  = ((e_in > 0) ? int'(e_in) - 1 : 0) + 2;
        return r;
      end
      m = longint'(frac) << k;
      e = int'(e_in) - k;
      r.lat = k + 3;
    end
    if (e >= 255) begin
      r.ovf = 1'b1;
      r.e   = 8'hFF;
      r.f   = '0;
    end else begin
      r.e = e[7:0];
      r.f = m[22:0];
    end
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [39:0] packed_result();
    return {5'd0, bus.sign_out, bus.exp_out, bus.frac_out,
            bus.zero_flag, bus.exp_overflow, bus.exp_underflow};
  endfunction

  function automatic logic [39:0] packed_model(input result_t r);
    return {5'd0, r.sign, r.e, r.f, r.zero, r.ovf, r.unf};
  endfunction

  task automatic scramble_inputs();
    bus.frac_in     = 24'($urandom);
    bus.overflow_in = 1'($urandom);
    bus.sign_in     = 1'($urandom);
    bus.exp_in      = 8'($urandom);
  endtask

  // One full transaction: accept, wait for DONE, hold under backpressure, release.
  task automatic apply_stimulus(input logic [23:0] frac, input logic ovf, input logic sgn,
                                input logic [7:0] e_in, input int hold, input string tag);
    result_t r;
    int      cycles;
    r = model(frac, ovf, sgn, e_in);
    check_output({tag, ".in_ready_idle"}, 40'(bus.in_ready), 40'd1);
    bus.in_valid    = 1'b1;
    bus.frac_in     = frac;
    bus.overflow_in = ovf;
    bus.sign_in     = sgn;
    bus.exp_in      = e_in;
    step();
    cycles = 1;
    scramble_inputs();
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      check_output({tag, ".in_ready_busy"}, 40'(bus.in_ready), 40'd0);
      step();
      scramble_inputs();
      cycles++;
    end
    check_output({tag, ".latency"}, 40'(cycles), 40'(r.lat));
    check_output({tag, ".result"}, packed_result(), packed_model(r));
    for (int i = 0; i < hold; i++) begin
      step();
      scramble_inputs();
      check_output({tag, ".hold_valid"}, 40'(bus.out_valid), 40'd1);
      check_output({tag, ".hold_ready"}, 40'(bus.in_ready), 40'd0);
      check_output({tag, ".hold_result"}, packed_result(), packed_model(r));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_output({tag, ".released_valid"}, 40'(bus.out_valid), 40'd0);
    check_output({tag, ".released_ready"}, 40'(bus.in_ready), 40'd1);
  endtask

  initial begin
    logic [23:0] frac;
    logic [7:0]  e_in;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.frac_in     = '0;
    bus.overflow_in = 1'b0;
    bus.sign_in     = 1'b0;
    bus.exp_in      = '0;

    repeat (3) step();
    check_output("reset.in_ready", 40'(bus.in_ready), 40'd0);
    check_output("reset.out_valid", 40'(bus.out_valid), 40'd0);
    check_output("reset.result", packed_result(), 40'd0);
    reset = 1'b0;
    #1;
    check_output("post_reset.in_ready", 40'(bus.in_ready), 40'd1);

    apply_stimulus(24'hFFFFFF, 1'b1, 1'b0, 8'd127, 0, "carry_round");
    apply_stimulus(24'h800000, 1'b0, 1'b1, 8'd100, 0, "already_normal");
    apply_stimulus(24'h000001, 1'b0, 1'b0, 8'd127, 0, "max_shift");
    apply_stimulus(24'h000001, 1'b0, 1'b1, 8'd10,  0, "underflow");
    apply_stimulus(24'h000000, 1'b0, 1'b1, 8'd55,  0, "exact_zero");
    apply_stimulus(24'h000000, 1'b1, 1'b0, 8'd254, 0, "exp_overflow");
    apply_stimulus(24'h000003, 1'b1, 1'b1, 8'd20,  0, "tie_odd");
    apply_stimulus(24'h400000, 1'b0, 1'b0, 8'd1,   0, "edge_exp1");
    apply_stimulus(24'h400000, 1'b0, 1'b0, 8'd2,   0, "edge_exp2");
    apply_stimulus(24'hC00000, 1'b0, 1'b0, 8'd255, 0, "normal_sat");
    apply_stimulus(24'h123456, 1'b0, 1'b1, 8'd90,  5, "backpressure");
    apply_stimulus(24'hABCDEF, 1'b1, 1'b0, 8'd60,  0, "back_to_back");

    // Reset arriving while the operand is still being shifted.
    bus.in_valid    = 1'b1;
    bus.frac_in     = 24'h000001;
    bus.overflow_in = 1'b0;
    bus.sign_in     = 1'b1;
    bus.exp_in      = 8'd127;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    check_output("mid_norm.busy", 40'(bus.in_ready), 40'd0);
    reset = 1'b1;
    step();
    check_output("mid_reset.out_valid", 40'(bus.out_valid), 40'd0);
    check_output("mid_reset.result", packed_result(), 40'd0);
    check_output("mid_reset.in_ready", 40'(bus.in_ready), 40'd0);
    reset = 1'b0;
    #1;
    check_output("after_reset.in_ready", 40'(bus.in_ready), 40'd1);
    apply_stimulus(24'h0F0F0F, 1'b0, 1'b0, 8'd140, 0, "after_reset");

    for (int n = 0; n < 40; n++) begin
      frac = 24'($urandom) >> $urandom_range(0, 23);
      if ($urandom_range(0, 7) == 0) frac = '0;
      case ($urandom_range(0, 5))
        0:       e_in = 8'($urandom_range(0, 3));
        1:       e_in = 8'($urandom_range(250, 255));
        default: e_in = 8'($urandom);
      endcase
      apply_stimulus(frac, ($urandom_range(0, 3) == 0), 1'($urandom), e_in,
                     $urandom_range(0, 3), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
